// File: rtl/lc2k_multicycle_ctrl.sv
// Multicycle control FSM for the LC2K CPU: fetch/decode/exec/mem/wb sequencing,
// datapath control decode and retired-instruction counting.
module lc2k_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_valb_sel,
    output logic             reg_write,
    output logic [1:0]       reg_dst_sel,
    output logic [1:0]       wb_sel,
    output logic [2:0]       opcode,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic [2:0]       w_op;
    logic [2:0]       w_rega;
    logic [2:0]       w_regb;
    logic [2:0]       w_dst;
    logic             w_unused_ir;

    assign w_op        = r_ir[24:22];
    assign w_rega      = r_ir[21:19];
    assign w_regb      = r_ir[18:16];
    assign w_dst       = r_ir[2:0];
    assign w_unused_ir = ^{r_ir[31:25], r_ir[15:3]};

    assign opcode      = w_op;
    assign instr_count = r_count;

    // State and instruction register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (ir_write) begin
                r_ir <= mem_rdata;
            end
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Next-state and retire decode
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_HALT: begin
                        w_state_nxt = S_HALT;
                        w_retire    = 1'b1;
                    end
                    OP_NOOP: begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                    default: w_state_nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_NOR: w_state_nxt = S_WB;
                    OP_LW, OP_SW:   w_state_nxt = S_MEM;
                    default: begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (w_op == OP_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_retire    = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_state_nxt = S_FETCH;
                w_retire    = 1'b1;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Datapath control decode
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_op       = 2'd0;
        alu_valb_sel = 1'b0;
        reg_write    = 1'b0;
        reg_dst_sel  = 2'd0;
        wb_sel       = 2'd0;
        halted       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_DECODE: begin
                pc_write = 1'b1;
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD: alu_valb_sel = 1'b1;
                    OP_NOR: begin
                        alu_op       = 2'd1;
                        alu_valb_sel = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op       = 2'd2;
                        alu_valb_sel = 1'b1;
                        pc_write     = alu_zero;
                        pc_src       = alu_zero ? 2'd1 : 2'd0;
                    end
                    OP_JALR: begin
                        reg_write   = (w_regb != 3'd0);
                        reg_dst_sel = 2'd1;
                        wb_sel      = 2'd2;
                        pc_write    = (w_rega != w_regb);
                        pc_src      = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_addr_sel = 1'b1;
                mem_read     = (w_op == OP_LW);
                mem_write    = (w_op != OP_LW);
            end
            S_WB: begin
                if (w_op == OP_LW) begin
                    reg_dst_sel = 2'd1;
                    wb_sel      = 2'd1;
                    reg_write   = (w_regb != 3'd0);
                end else begin
                    reg_write   = (w_dst != 3'd0);
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        // Strobes are suppressed while reset is held so no access leaks through it
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Directed bench for lc2k_multicycle_ctrl: per-cycle control-word checks over
// a hand-written instruction sequence, plus a 4-bit counter wrap instance.
module tb_lc2k_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        alu_zero;
    logic        mem_read, mem_write, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_op, reg_dst_sel, wb_sel;
    logic        alu_valb_sel, reg_write, halted;
    logic [2:0]  opcode;
    logic [31:0] instr_count;

    logic        reset4;
    logic        mem_read4, mem_write4, mem_addr_sel4, ir_write4, pc_write4;
    logic [1:0]  pc_src4, alu_op4, reg_dst_sel4, wb_sel4;
    logic        alu_valb_sel4, reg_write4, halted4;
    logic [2:0]  opcode4;
    logic [3:0]  instr_count4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lc2k_multicycle_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_op(alu_op), .alu_valb_sel(alu_valb_sel),
        .reg_write(reg_write), .reg_dst_sel(reg_dst_sel), .wb_sel(wb_sel),
        .opcode(opcode), .halted(halted), .instr_count(instr_count)
    );

    lc2k_multicycle_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset4), .mem_rdata(32'h01C0_0000), .mem_ready(1'b1),
        .alu_zero(1'b0), .mem_read(mem_read4), .mem_write(mem_write4),
        .mem_addr_sel(mem_addr_sel4), .ir_write(ir_write4), .pc_write(pc_write4),
        .pc_src(pc_src4), .alu_op(alu_op4), .alu_valb_sel(alu_valb_sel4),
        .reg_write(reg_write4), .reg_dst_sel(reg_dst_sel4), .wb_sel(wb_sel4),
        .opcode(opcode4), .halted(halted4), .instr_count(instr_count4)
    );

    logic [31:0] w_ctl;
    assign w_ctl = {16'd0, mem_read, mem_write, mem_addr_sel, ir_write, pc_write,
                    pc_src, alu_op, alu_valb_sel, reg_write, reg_dst_sel, wb_sel, halted};

    function automatic logic [31:0] ctl(input bit mr, input bit mw, input bit mas,
                                        input bit irw, input bit pcw, input bit [1:0] pcs,
                                        input bit [1:0] aop, input bit vb, input bit rw,
                                        input bit [1:0] rds, input bit [1:0] wbs, input bit h);
        return {16'd0, mr, mw, mas, irw, pcw, pcs, aop, vb, rw, rds, wbs, h};
    endfunction

    function automatic logic [31:0] enc(input bit [2:0] op, input bit [2:0] ra,
                                        input bit [2:0] rb, input bit [15:0] lo);
        return {7'd0, op, ra, rb, lo};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One controller cycle: drive inputs, check control word, advance past the edge
    task automatic cyc(input string tag, input logic rdy, input logic zero,
                       input logic [31:0] instr, input logic [31:0] exp);
        mem_ready = rdy;
        alu_zero  = zero;
        mem_rdata = instr;
        #1;
        chk(tag, w_ctl, exp);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] FETCH_RDY, FETCH_WAIT, DEC, HLT, NONE;
    logic [31:0] ADD123, HALTI, LW015, BEQ127, JALR45, JALR33, ADD120, JALR10;
    logic [31:0] NOR345, NOOP, SW015;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        FETCH_RDY  = ctl(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        FETCH_WAIT = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DEC        = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        HLT        = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        NONE       = 32'd0;
        ADD123 = enc(0, 1, 2, 3);
        HALTI  = enc(6, 0, 0, 0);
        LW015  = enc(2, 0, 1, 5);
        BEQ127 = enc(4, 1, 2, 7);
        JALR45 = enc(5, 4, 5, 0);
        JALR33 = enc(5, 3, 3, 0);
        ADD120 = enc(0, 1, 2, 0);
        JALR10 = enc(5, 1, 0, 0);
        NOR345 = enc(1, 3, 4, 5);
        NOOP   = enc(7, 0, 0, 0);
        SW015  = enc(3, 0, 1, 5);

        reset = 1'b1; reset4 = 1'b1;
        mem_ready = 1'b1; alu_zero = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", w_ctl, NONE);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_op", 32'(opcode), 32'd0);
        reset = 1'b0;

        // add 1 2 3 ; halt
        cyc("add_f", 1, 0, ADD123, FETCH_RDY);
        cyc("add_d", 1, 0, 32'd0, DEC);
        cyc("add_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc("add_w", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        chk("add_cnt", instr_count, 32'd1);
        cyc("hlt_f", 1, 0, HALTI, FETCH_RDY);
        chk("hlt_op", 32'(opcode), 32'd6);
        cyc("hlt_d", 1, 0, 32'd0, DEC);
        chk("hlt_cnt", instr_count, 32'd2);
        cyc("hlt_h0", 1, 0, ADD123, HLT);
        cyc("hlt_h1", 1, 1, ADD123, HLT);
        chk("hlt_cnt2", instr_count, 32'd2);

        reset = 1'b1;
        #1;
        chk("rst2_ctl", w_ctl, NONE);
        chk("rst2_cnt", instr_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw 0 1 5 with three wait cycles in MEM
        cyc("lw_f", 1, 0, LW015, FETCH_RDY);
        cyc("lw_d", 1, 0, 32'd0, DEC);
        cyc("lw_e", 1, 0, 32'd0, NONE);
        cyc("lw_m0", 0, 0, 32'd0, ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_m1", 0, 0, 32'd0, ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_m2", 0, 0, 32'd0, ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_m3", 1, 0, 32'd0, ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("lw_w", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        chk("lw_cnt", instr_count, 32'd1);

        // beq taken then not taken
        cyc("beqt_f", 1, 0, BEQ127, FETCH_RDY);
        cyc("beqt_d", 1, 0, 32'd0, DEC);
        cyc("beqt_e", 1, 1, 32'd0, ctl(0, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0));
        cyc("beqn_f", 1, 0, BEQ127, FETCH_RDY);
        cyc("beqn_d", 1, 0, 32'd0, DEC);
        cyc("beqn_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        chk("beq_cnt", instr_count, 32'd3);

        // jalr 4 5 ; jalr 3 3
        cyc("jalr_f", 1, 0, JALR45, FETCH_RDY);
        cyc("jalr_d", 1, 0, 32'd0, DEC);
        cyc("jalr_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 2, 0));
        cyc("jalr33_f", 1, 0, JALR33, FETCH_RDY);
        cyc("jalr33_d", 1, 0, 32'd0, DEC);
        cyc("jalr33_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 2, 0));
        chk("jalr_cnt", instr_count, 32'd5);

        // destination register 0 never written
        cyc("add0_f", 1, 0, ADD120, FETCH_RDY);
        cyc("add0_d", 1, 0, 32'd0, DEC);
        cyc("add0_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc("add0_w", 1, 0, 32'd0, NONE);
        cyc("jalr0_f", 1, 0, JALR10, FETCH_RDY);
        cyc("jalr0_d", 1, 0, 32'd0, DEC);
        cyc("jalr0_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0));
        chk("r0_cnt", instr_count, 32'd7);

        // nor 3 4 5 ; noop
        cyc("nor_f", 1, 0, NOR345, FETCH_RDY);
        chk("nor_op", 32'(opcode), 32'd1);
        cyc("nor_d", 1, 0, 32'd0, DEC);
        cyc("nor_e", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        cyc("nor_w", 1, 0, 32'd0, ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("noop_f", 1, 0, NOOP, FETCH_RDY);
        cyc("noop_d", 1, 0, 32'd0, DEC);
        chk("noop_cnt", instr_count, 32'd9);

        // sw with a fetch wait, then reset in the middle of MEM
        cyc("sw_fw", 0, 0, SW015, FETCH_WAIT);
        cyc("sw_f", 1, 0, SW015, FETCH_RDY);
        cyc("sw_d", 1, 0, 32'd0, DEC);
        cyc("sw_e", 1, 0, 32'd0, NONE);
        cyc("sw_m0", 0, 0, 32'd0, ctl(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        #1;
        chk("sw_m1", w_ctl, ctl(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        #1;
        chk("sw_rst_ctl", w_ctl, NONE);
        chk("sw_rst_cnt", instr_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("post_rst_f", 1, 0, NOOP, FETCH_RDY);
        chk("post_rst_cnt", instr_count, 32'd0);

        // 16 noops through a 4-bit counter wrap it back to zero
        reset4 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("wrap_15", 32'(instr_count4), 32'd15);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_0", 32'(instr_count4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lc2k_multicycle_ctrl.md
Name: lc2k_multicycle_ctrl

Overview:
Multicycle control FSM for the LC2K CPU. It fetches and latches each instruction, decodes the opcode, and sequences the shared ALU, ALU valB mux, memory port, register file and PC through FETCH/DECODE/EXEC/MEM/WB. It also counts retired instructions and holds in HALT after a halt opcode.

Parameters:
CNT_W, 32, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
mem_rdata  input  32  memory read data (instruction word in FETCH)
mem_ready  input  1  memory completes the current read/write this cycle
alu_zero  input  1  ALU result == 0 (valid in EXEC)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr_sel  output  1  0 = PC, 1 = ALU result
ir_write  output  1  datapath IR load enable
pc_write  output  1  PC load enable
pc_src  output  2  0 = PC+1, 1 = PC+1+offset, 2 = regA value
alu_op  output  2  0 = add, 1 = nor, 2 = subtract (compare)
alu_valb_sel  output  1  1 = regB value, 0 = sign-extended offset (drives CONTROL_ALUvalB)
reg_write  output  1  register file write enable
reg_dst_sel  output  2  0 = destReg field [2:0], 1 = regB field [18:16]
wb_sel  output  2  0 = ALU result, 1 = mem_rdata, 2 = PC (already PC+1)
opcode  output  3  latched IR[24:22]
halted  output  1  high while in HALT
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- State register and internal IR are registered. Outputs are decoded combinationally from state, IR, alu_zero and mem_ready (Moore except where noted).
- Reset (async, any state, mid-access included): state = FETCH; IR = 0; instr_count = 0; halted = 0. Once reset deasserts, the first edge begins a fetch. No memory strobe persists through reset.
- Default for every output is 0 unless asserted below.
- FETCH:
  - Outputs: mem_read = 1, mem_addr_sel = 0.
  - Wait while mem_ready = 0.
  - On mem_ready = 1: ir_write = 1, latch mem_rdata into IR, go to DECODE.
- DECODE:
  - Outputs: pc_write = 1, pc_src = 0.
  - Opcode 000/001/010/011/100/101 -> EXEC.
  - 110 (halt) -> HALT, count +1.
  - 111 (noop) -> FETCH, count +1.
- EXEC:
  - add: alu_op = 0, alu_valb_sel = 1 -> WB.
  - nor: alu_op = 1, alu_valb_sel = 1 -> WB.
  - lw/sw: alu_op = 0, alu_valb_sel = 0 -> MEM.
  - beq: alu_op = 2, alu_valb_sel = 1. If alu_zero = 1: pc_write = 1, pc_src = 1. -> FETCH, count +1.
  - jalr: reg_write = 1, reg_dst_sel = 1, wb_sel = 2; pc_write = 1, pc_src = 2. -> FETCH, count +1.
    - If regA field == regB field: pc_write = 0, so PC stays at PC+1.
- MEM:
  - lw: mem_read = 1, mem_addr_sel = 1. Wait for mem_ready, then -> WB.
  - sw: mem_write = 1, mem_addr_sel = 1. Wait for mem_ready, then -> FETCH, count +1.
  - Strobes stay high continuously until the mem_ready cycle.
- WB:
  - reg_write = 1. add/nor: reg_dst_sel = 0, wb_sel = 0. lw: reg_dst_sel = 1, wb_sel = 1.
  - -> FETCH, count +1.
- Register 0 is hardwired zero: reg_write is forced to 0 whenever the selected destination field == 0 (WB and jalr).
- HALT: halted = 1, all strobes 0. Absorbing; only reset leaves it.
- Latency with mem_ready tied high:
  - add/nor 4 cycles; lw 5; sw 4; beq/jalr 3; noop 2; halt enters HALT after 2.
  - Each wait cycle on mem_ready adds 1.
- instr_count increments exactly once per instruction, on the edge leaving the instruction's final state. It wraps from 2^CNT_W-1 to 0.
- All 8 opcodes are defined; no illegal-opcode state exists.

Test Plan:
- mem_ready = 1, program add 1 2 3; halt -> add takes 4 cycles with reg_write = 1, reg_dst_sel = 0 only in WB; halted = 1 at cycle 6; instr_count = 2.
- lw 0 1 5 with mem_ready low for 3 cycles in MEM -> mem_read = 1, mem_addr_sel = 1 held 4 cycles; WB: reg_dst_sel = 1, wb_sel = 1; lw totals 8 cycles.
- beq 1 2 off with alu_zero = 1, then with alu_zero = 0 -> pc_write/pc_src = 1 in EXEC only when taken; both return to FETCH after 3 cycles.
- jalr 4 5, then jalr 3 3 -> first: reg_write = 1, pc_write = 1, pc_src = 2. Second: reg_write = 1, pc_write = 0 in EXEC.
- add 1 2 0 and jalr 1 0 -> reg_write stays 0 throughout (dest reg 0).
- Assert reset mid-MEM of sw (mem_write = 1) -> mem_write drops immediately; after release state = FETCH, instr_count = 0, halted = 0. Preload CNT_W = 4, run 16 noops -> instr_count wraps to 0.
